// File: rtl/log_pkg.sv
// Shared types for the iterative log2 block: FSM states and the rounding mode.
package log_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    MODE_FLOOR = 1'b0,
    MODE_CEIL  = 1'b1
  } mode_t;

endpackage

// File: rtl/clog2_iter.sv
// Iterative floor/ceil log2: scans the operand from the MSB down, one bit per
// cycle, and holds the result until the consumer takes it.
module clog2_iter
  import log_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int OUT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_zero,
  output logic             out_pow2,
  output logic             busy
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] operand;
  mode_t            mode;
  logic [IDX_W-1:0] idx;

  logic             accept;
  logic             bit_hit;
  logic             last_bit;
  logic [WIDTH-1:0] remainder;
  logic             rem_zero;
  logic [OUT_W-1:0] result;

  assign accept    = in_valid && in_ready;
  assign bit_hit   = operand[idx];
  assign last_bit  = (idx == '0);
  // Bits above idx are already known zero, so clearing idx leaves only the tail.
  assign remainder = operand & ~(WIDTH'(1) << idx);
  assign rem_zero  = (remainder == '0);
  assign result    = OUT_W'(idx) +
                     (((mode == MODE_CEIL) && !rem_zero) ? OUT_W'(1) : OUT_W'(0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid)             state_next = SCAN;
      SCAN: if (bit_hit || last_bit)  state_next = DONE;
      DONE: if (out_ready)            state_next = IDLE;
      default:                        state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state != IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      operand  <= '0;
      mode     <= MODE_FLOOR;
      idx      <= IDX_TOP;
      out_data <= '0;
      out_zero <= 1'b0;
      out_pow2 <= 1'b0;
    end else begin
      if (accept) begin
        operand <= in_data;
        mode    <= mode_t'(in_mode);
        idx     <= IDX_TOP;
      end else if (state == SCAN) begin
        if (bit_hit) begin
          out_data <= result;
          out_zero <= 1'b0;
          out_pow2 <= rem_zero;
        end else if (last_bit) begin
          out_data <= '0;
          out_zero <= 1'b1;
          out_pow2 <= 1'b0;
        end else begin
          idx <= idx - IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_clog2_iter.sv
// Self-checking bench for clog2_iter at WIDTH=8 and WIDTH=32 against an
// arithmetic log2 reference model.
module tb_clog2_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       in_valid8 = 1'b0, in_mode8 = 1'b0, out_ready8 = 1'b0;
  logic [7:0] in_data8 = '0;
  logic       in_ready8, out_valid8, out_zero8, out_pow28, busy8;
  logic [3:0] out_data8;

  logic        in_valid32 = 1'b0, in_mode32 = 1'b0, out_ready32 = 1'b0;
  logic [31:0] in_data32 = '0;
  logic        in_ready32, out_valid32, out_zero32, out_pow232, busy32;
  logic [5:0]  out_data32;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  clog2_iter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8), .in_mode(in_mode8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
    .out_zero(out_zero8), .out_pow2(out_pow28), .busy(busy8)
  );

  clog2_iter #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid32), .in_ready(in_ready32), .in_data(in_data32), .in_mode(in_mode32),
    .out_valid(out_valid32), .out_ready(out_ready32), .out_data(out_data32),
    .out_zero(out_zero32), .out_pow2(out_pow232), .busy(busy32)
  );

  // Reference: largest f with 2^f <= x (0 for x==0)
  function automatic int ref_floor(input logic [31:0] x);
    longint v = longint'(x);
    int f = 0;
    while ((longint'(1) << (f + 1)) <= v) f++;
    return f;
  endfunction

  // Reference: smallest c with 2^c >= x (0 for x<=1)
  function automatic int ref_ceil(input logic [31:0] x);
    longint v = longint'(x);
    int c = 0;
    while ((longint'(1) << c) < v) c++;
    return c;
  endfunction

  task automatic run_op(input int w, input logic [31:0] d, input logic m, input string tag);
    logic [31:0] x;
    int exp_data, exp_lat, lat, got_data;
    logic exp_zero, exp_pow2, seen, got_zero, got_pow2, got_valid, got_ready;
    x = (w == 8) ? (d & 32'hFF) : d;
    exp_zero = (x == 0);
    exp_pow2 = (x != 0) && ((x & (x - 1)) == 0);
    exp_data = exp_zero ? 0 : (m ? ref_ceil(x) : ref_floor(x));
    exp_lat  = exp_zero ? w : w - ref_floor(x);

    @(negedge clk);
    if (w == 8) begin
      in_valid8 = 1'b1; in_data8 = x[7:0]; in_mode8 = m;
    end else begin
      in_valid32 = 1'b1; in_data32 = x; in_mode32 = m;
    end
    @(posedge clk); #1;
    in_valid8 = 1'b0; in_valid32 = 1'b0;

    lat = 0; seen = 1'b0;
    while (!seen && lat < w + 4) begin
      @(posedge clk); #1;
      lat++;
      seen = (w == 8) ? out_valid8 : out_valid32;
    end

    total++;
    if (!seen) begin
      bad++;
      $display("[TB] FAIL %s timeout: out_valid never rose, required latency %0d", tag, exp_lat);
      return;
    end
    got_data = (w == 8) ? int'(out_data8) : int'(out_data32);
    got_zero = (w == 8) ? out_zero8 : out_zero32;
    got_pow2 = (w == 8) ? out_pow28 : out_pow232;
    if (lat !== exp_lat) begin
      bad++;
      $display("[TB] FAIL %s latency x=%0h: got %0d required %0d", tag, x, lat, exp_lat);
    end
    total++;
    if (got_data !== exp_data) begin
      bad++;
      $display("[TB] FAIL %s data x=%0h mode=%0d: got %0d required %0d", tag, x, m, got_data, exp_data);
    end
    total++;
    if (got_zero !== exp_zero || got_pow2 !== exp_pow2) begin
      bad++;
      $display("[TB] FAIL %s flags x=%0h: got zero=%0b pow2=%0b required zero=%0b pow2=%0b",
               tag, x, got_zero, got_pow2, exp_zero, exp_pow2);
    end

    @(negedge clk);
    if (w == 8) out_ready8 = 1'b1; else out_ready32 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0; out_ready32 = 1'b0;
    got_valid = (w == 8) ? out_valid8 : out_valid32;
    got_ready = (w == 8) ? in_ready8 : in_ready32;
    total++;
    if (got_valid !== 1'b0 || got_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL %s handshake: got out_valid=%0b in_ready=%0b required 0/1", tag, got_valid, got_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    total++;
    if ({in_ready8, out_valid8, out_data8, out_zero8, out_pow28, busy8} !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL reset8: got rdy=%0b vld=%0b data=%0d z=%0b p=%0b busy=%0b required 1 0 0 0 0 0",
               in_ready8, out_valid8, out_data8, out_zero8, out_pow28, busy8);
    end
    total++;
    if ({in_ready32, out_valid32, out_data32, busy32} !== {1'b1, 1'b0, 6'd0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL reset32: got rdy=%0b vld=%0b data=%0d busy=%0b required 1 0 0 0",
               in_ready32, out_valid32, out_data32, busy32);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    run_op(8, 32'h05, 1'b1, "dir_05_ceil");
    run_op(8, 32'h05, 1'b0, "dir_05_floor");
    run_op(8, 32'h80, 1'b1, "dir_80_ceil");
    run_op(8, 32'hFF, 1'b1, "dir_ff_ceil");
    run_op(8, 32'h00, 1'b1, "dir_zero");
    run_op(8, 32'h01, 1'b1, "dir_one_ceil");
    run_op(32, 32'h8000_0000, 1'b0, "dir32_top");
    run_op(32, 32'hFFFF_FFFF, 1'b1, "dir32_ff_ceil");
  endtask

  task automatic test_stall();
    logic [3:0] held_data;
    logic held_z, held_p;
    int lat;
    @(negedge clk);
    in_valid8 = 1'b1; in_data8 = 8'h05; in_mode8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (!out_valid8) begin
      bad++;
      $display("[TB] FAIL stall_timeout: out_valid=%0b required 1", out_valid8);
      return;
    end
    held_data = out_data8; held_z = out_zero8; held_p = out_pow28;
    total++;
    if (held_data !== 4'd3) begin
      bad++;
      $display("[TB] FAIL stall_data: got %0d required 3", held_data);
    end
    @(negedge clk);
    in_valid8 = 1'b1; in_data8 = 8'h80; in_mode8 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid8 !== 1'b1 || in_ready8 !== 1'b0 || busy8 !== 1'b1 ||
          out_data8 !== held_data || out_zero8 !== held_z || out_pow28 !== held_p) begin
        bad++;
        $display("[TB] FAIL stall_hold cycle %0d: got vld=%0b rdy=%0b busy=%0b data=%0d required 1 0 1 %0d",
                 i, out_valid8, in_ready8, busy8, out_data8, held_data);
      end
    end
    @(negedge clk);
    in_valid8 = 1'b0; out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    total++;
    if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL stall_release: got rdy=%0b vld=%0b required 1 0", in_ready8, out_valid8);
    end
    @(posedge clk); #1;
    total++;
    if (busy8 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL stall_ignored: got busy=%0b required 0", busy8);
    end
  endtask

  task automatic test_reset_mid_scan();
    logic saw_valid;
    @(negedge clk);
    in_valid8 = 1'b1; in_data8 = 8'h01; in_mode8 = 1'b0;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    total++;
    if (in_ready8 !== 1'b1 || busy8 !== 1'b0 || out_valid8 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midscan_reset: got rdy=%0b busy=%0b vld=%0b required 1 0 0", in_ready8, busy8, out_valid8);
    end
    @(negedge clk);
    rst = 1'b0;
    saw_valid = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid8) saw_valid = 1'b1;
    end
    total++;
    if (saw_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midscan_discard: got out_valid seen=%0b required 0", saw_valid);
    end
    run_op(8, 32'h10, 1'b0, "after_reset_10");
  endtask

  task automatic test_random();
    logic [31:0] d;
    for (int i = 0; i < 200; i++) begin
      d = (i % 17 == 0) ? 32'h0 : 32'($urandom_range(0, 255));
      run_op(8, d, 1'($urandom_range(0, 1)), "rand8");
    end
    for (int i = 0; i < 200; i++) begin
      d = (i % 23 == 0) ? 32'h0 : ($urandom >> $urandom_range(0, 31));
      run_op(32, d, 1'($urandom_range(0, 1)), "rand32");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid_scan();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clog2_iter.md
CLOG2_ITER -- requirements
Module: clog2_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 2..64).
REQ-002 SHALL have derived localparam OUT_W = $clog2(WIDTH+1), result width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  request offered.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port in_data  input  WIDTH  operand.
REQ-008 SHALL have port in_mode  input  1  0 = floor(log2), 1 = ceil(log2).
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port out_data  output  OUT_W  result.
REQ-012 SHALL have port out_zero  output  1  operand was zero.
REQ-013 SHALL have port out_pow2  output  1  operand was an exact power of two.
REQ-014 SHALL have port busy  output  1  high in SCAN or DONE.

Function
REQ-015 SHALL implement FSM states IDLE, SCAN, DONE; in_ready = (state == IDLE), combinational from state only.
REQ-016 SHALL accept when in_valid && in_ready at a posedge: latch in_data, in_mode; set bit index idx = WIDTH-1; go to SCAN.
REQ-017 SHALL, in SCAN, test exactly one bit per cycle, operand[idx], idx decrementing by 1 each cycle.
REQ-018 SHALL, when operand[idx]==1, register floor = idx, pow2 = (operand with bit idx cleared == 0), and go to DONE.
REQ-019 SHALL, when idx==0 and operand[0]==0, register zero = 1, result 0, pow2 = 0, and go to DONE.
REQ-020 SHALL produce out_data = floor in mode 0; floor + (pow2 ? 0 : 1) in mode 1; ceil(log2(1)) = 0; zero operand gives 0 in both modes (matches $clog2(0)).
REQ-021 SHALL assert out_valid in the cycle after the deciding SCAN edge: for leading-one position p, out_valid rises (WIDTH-p) edges after the accept edge; for a zero operand, WIDTH edges after.
REQ-022 SHALL hold out_valid, out_data, out_zero, out_pow2 stable in DONE until out_valid && out_ready at a posedge, then return to IDLE.
REQ-023 SHALL deassert out_valid the cycle after handshake; in_ready high that same cycle; no back-to-back overlap of requests.
REQ-024 SHALL ignore in_valid, in_data and in_mode while not in IDLE.
REQ-025 SHALL keep out_data/out_zero/out_pow2 at their last values outside DONE (qualified only by out_valid).

Reset
REQ-026 SHALL, on rst high, asynchronously force state IDLE, idx = WIDTH-1, out_valid 0, out_data 0, out_zero 0, out_pow2 0, busy 0 (in_ready therefore 1).
REQ-027 SHALL, on reset during SCAN or DONE, discard the operation with no result emitted; first accept after release behaves as fresh.

Structure
REQ-028 SHALL place the state enum (IDLE/SCAN/DONE) and the mode enum (MODE_FLOOR=0, MODE_CEIL=1) in shared package log_pkg.
REQ-029 SHALL be a single module; no sub-module required (bit test and remainder-zero check are inline logic).

Verification
REQ-030 SHALL check: WIDTH=8, in_data=8'b0000_0101, mode 1 -> out_data=3, out_pow2=0, out_zero=0, out_valid 6 edges after accept; mode 0 -> out_data=2.
REQ-031 SHALL check: in_data=8'h80 mode 1 -> out_data=7, out_pow2=1, out_valid 1 edge after accept; in_data=8'hFF mode 1 -> out_data=8 (OUT_W=4).
REQ-032 SHALL check: in_data=0 -> out_data=0, out_zero=1, out_valid 8 edges after accept; in_data=1 mode 1 -> out_data=0, out_pow2=1.
REQ-033 SHALL check: out_ready held low 5 cycles in DONE -> outputs stable, in_ready low, second in_valid ignored; out_ready high -> in_ready high next cycle.
REQ-034 SHALL check: rst pulse mid-SCAN -> out_valid never asserts, in_ready high immediately; next request 8'h10 mode 0 -> 4.
REQ-035 SHALL check: 200 random operands/modes with WIDTH=8 and WIDTH=32 -> ceil results equal $clog2(in_data), floor results equal $clog2(in_data+1)-1 for nonzero operands, latency per REQ-021.
